// File: rtl/uart_axis_rx.sv
// 8N1 UART receiver (LSB first) presenting received bytes as an AXI-Stream byte master.
// Define UART_RX_FIFO_EN to replace the single holding register with a 4-entry FIFO.
module uart_axis_rx (
    input  logic        clk,
    input  logic        rst,
    input  logic        rxd,
    input  logic [15:0] prescale,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        busy,
    output logic        overrun_error,
    output logic        frame_error
);
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    state_t      state_reg, state_next;
    logic [1:0]  sync_reg;
    logic        rxd_s;
    logic [18:0] cnt_reg, cnt_next;
    logic [15:0] p_reg, p_next;
    logic [2:0]  bit_reg, bit_next;
    logic [7:0]  shift_reg, shift_next;
    logic        fe_reg, fe_next;
    logic        oe_reg, oe_next;
    logic        deliver;
    logic        sample;
    logic [15:0] p_eff;
    logic [18:0] period_m1;

    // Both synchronizer flops reset high so that a line held low through
    // reset is not mistaken for a start bit until two cycles after release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], rxd};
        end
    end
    assign rxd_s = sync_reg[1];

    assign p_eff     = (prescale == 16'd0) ? 16'd1 : prescale;
    assign period_m1 = {p_reg, 3'b000} - 19'd1;
    assign sample    = (cnt_reg == 19'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            p_reg     <= 16'd1;
            bit_reg   <= '0;
            shift_reg <= '0;
            fe_reg    <= 1'b0;
            oe_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            p_reg     <= p_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
            fe_reg    <= fe_next;
            oe_reg    <= oe_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        p_next     = p_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        deliver    = 1'b0;
        fe_next    = 1'b0;
        if (cnt_reg != 19'd0) begin
            cnt_next = cnt_reg - 19'd1;
        end
        case (state_reg)
            IDLE: begin
                if (!rxd_s) begin
                    // Half a bit period puts the start sample mid-bit.
                    p_next     = p_eff;
                    cnt_next   = {1'b0, p_eff, 2'b00} - 19'd1;
                    state_next = START;
                end
            end
            START: begin
                if (sample) begin
                    if (!rxd_s) begin
                        cnt_next   = period_m1;
                        bit_next   = 3'd0;
                        state_next = DATA;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            DATA: begin
                if (sample) begin
                    shift_next = {rxd_s, shift_reg[7:1]};
                    cnt_next   = period_m1;
                    if (bit_reg == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_next = bit_reg + 3'd1;
                    end
                end
            end
            STOP: begin
                if (sample) begin
                    if (rxd_s) begin
                        deliver    = 1'b1;
                        state_next = IDLE;
                    end else begin
                        fe_next    = 1'b1;
                        state_next = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                if (rxd_s) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy          = (state_reg != IDLE);
    assign frame_error   = fe_reg;
    assign overrun_error = oe_reg;

`ifdef UART_RX_FIFO_EN
    logic [7:0] mem [4];
    logic [1:0] wr_ptr_reg;
    logic [1:0] rd_ptr_reg;
    logic [2:0] count_reg;
    logic       full;
    logic       rd_en;
    logic       wr_en;

    assign full  = (count_reg == 3'd4);
    assign rd_en = (count_reg != 3'd0) && m_axis_tready;
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign wr_en = deliver && (!full || m_axis_tready);

    always_comb begin
        oe_next = deliver && !wr_en;
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_mem
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    mem[gi] <= 8'h00;
                end else if (wr_en && (wr_ptr_reg == gi[1:0])) begin
                    mem[gi] <= shift_reg;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + 2'd1;
            end
            if (rd_en) begin
                rd_ptr_reg <= rd_ptr_reg + 2'd1;
            end
            count_reg <= count_reg + {2'b00, wr_en} - {2'b00, rd_en};
        end
    end

    assign m_axis_tdata  = mem[rd_ptr_reg];
    assign m_axis_tvalid = (count_reg != 3'd0);
`else
    logic [7:0] tdata_reg;
    logic       tvalid_reg;
    logic       space;

    assign space = !tvalid_reg || m_axis_tready;

    always_comb begin
        oe_next = deliver && !space;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tdata_reg  <= 8'h00;
            tvalid_reg <= 1'b0;
        end else if (deliver && space) begin
            tdata_reg  <= shift_reg;
            tvalid_reg <= 1'b1;
        end else if (tvalid_reg && m_axis_tready) begin
            tvalid_reg <= 1'b0;
        end
    end

    assign m_axis_tdata  = tdata_reg;
    assign m_axis_tvalid = tvalid_reg;
`endif
endmodule

// File: tb/tb_uart_axis_rx.sv
// Directed bench for uart_axis_rx; expected edges are written relative to T, the
// first clock edge that sees the line low.
module tb_uart_axis_rx;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rxd = 1'b1;
    logic [15:0] prescale = 16'd2;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b0;
    logic        busy;
    logic        overrun_error;
    logic        frame_error;

    uart_axis_rx dut (
        .clk           (clk),
        .rst           (rst),
        .rxd           (rxd),
        .prescale      (prescale),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .busy          (busy),
        .overrun_error (overrun_error),
        .frame_error   (frame_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    // Event recorder, sampled mid-cycle. Edge numbers: "cyc+1" is the edge that
    // samples the value seen now; busy changes are logged at the edge that caused them.
    int         vr_n = 0, vr_edge = 0, vcyc_n = 0;
    int         fe_n = 0, fe_edge = 0;
    int         oe_n = 0, oe_edge = 0;
    int         bz_rise = 0, bz_fall = 0;
    logic [7:0] got_d [64];
    int         got_e [64];
    int         got_n = 0;
    logic       tv_prev = 1'b0;
    logic       bz_prev = 1'b0;

    always @(negedge clk) begin
        if (m_axis_tvalid && !tv_prev) begin
            vr_n++;
            vr_edge = cyc + 1;
        end
        if (m_axis_tvalid) vcyc_n++;
        if (m_axis_tvalid && m_axis_tready && got_n < 64) begin
            got_d[got_n] = m_axis_tdata;
            got_e[got_n] = cyc + 1;
            got_n++;
        end
        if (frame_error) begin
            fe_n++;
            fe_edge = cyc + 1;
        end
        if (overrun_error) begin
            oe_n++;
            oe_edge = cyc + 1;
        end
        if (busy && !bz_prev) bz_rise = cyc;
        if (!busy && bz_prev) bz_fall = cyc;
        tv_prev = m_axis_tvalid;
        bz_prev = busy;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives start, 8 data bits and the stop level; the line is left at the stop level.
    task automatic send_frame(input logic [7:0] d, input logic stopv, input int blen,
                              input logic bump, output int t);
        t = cyc + 1;
        rxd = 1'b0;
        step(blen);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            if (bump && i == 2) prescale = 16'd7;
            step(blen);
        end
        rxd = stopv;
        step(blen);
    endtask

    int t, t1, t2, t5;
    int vr0, fe0, oe0, g0, vc0;

    initial begin
        #1 rst = 1'b1;
        step(3);
        chk("rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        chk("rst_tdata", {24'd0, m_axis_tdata}, 32'h00);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_errs", {30'd0, frame_error, overrun_error}, 32'd0);
        rst = 1'b0;
        step(10);

        // Single byte, P=2, consumer ready.
        m_axis_tready = 1'b1;
        vr0 = vr_n; fe0 = fe_n; oe0 = oe_n; g0 = got_n; vc0 = vcyc_n;
        send_frame(8'h55, 1'b1, 16, 1'b0, t);
        rxd = 1'b1;
        step(10);
        chk("b55_rise_n", vr_n - vr0, 1);
        chk("b55_rise_edge", vr_edge, t + 155);
        chk("b55_high_cycles", vcyc_n - vc0, 1);
        chk("b55_count", got_n - g0, 1);
        chk("b55_data", {24'd0, got_d[g0]}, 32'h55);
        chk("b55_xfer_edge", got_e[g0], t + 155);
        chk("b55_no_err", (fe_n - fe0) + (oe_n - oe0), 0);
        chk("b55_busy_rise", bz_rise, t + 2);
        chk("b55_busy_fall", bz_fall, t + 154);

        // Back-to-back frames with consumer stalled.
        m_axis_tready = 1'b0;
        vr0 = vr_n; oe0 = oe_n; g0 = got_n;
`ifdef UART_RX_FIFO_EN
        send_frame(8'h01, 1'b1, 16, 1'b0, t1);
        send_frame(8'h02, 1'b1, 16, 1'b0, t);
        send_frame(8'h03, 1'b1, 16, 1'b0, t);
        send_frame(8'h04, 1'b1, 16, 1'b0, t);
        send_frame(8'h05, 1'b1, 16, 1'b0, t5);
        step(5);
        chk("ff_rise_edge", vr_edge, t1 + 155);
        chk("ff_oe_n", oe_n - oe0, 1);
        chk("ff_oe_edge", oe_edge, t5 + 155);
        chk("ff_head", {24'd0, m_axis_tdata}, 32'h01);
        chk("ff_no_xfer", got_n - g0, 0);
        m_axis_tready = 1'b1;
        step(8);
        chk("ff_drain_n", got_n - g0, 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("ff_drain_d%0d", i), {24'd0, got_d[g0 + i]}, i + 1);
            chk($sformatf("ff_drain_e%0d", i), got_e[g0 + i], got_e[g0] + i);
        end
        chk("ff_empty", {31'd0, m_axis_tvalid}, 32'd0);
`else
        send_frame(8'hA5, 1'b1, 16, 1'b0, t1);
        send_frame(8'h3C, 1'b1, 16, 1'b0, t2);
        step(5);
        chk("ov_rise_n", vr_n - vr0, 1);
        chk("ov_rise_edge", vr_edge, t1 + 155);
        chk("ov_oe_n", oe_n - oe0, 1);
        chk("ov_oe_edge", oe_edge, t2 + 155);
        chk("ov_tvalid", {31'd0, m_axis_tvalid}, 32'd1);
        chk("ov_tdata_held", {24'd0, m_axis_tdata}, 32'hA5);
        chk("ov_no_xfer", got_n - g0, 0);
        m_axis_tready = 1'b1;
        step(3);
        chk("ov_xfer_n", got_n - g0, 1);
        chk("ov_xfer_d", {24'd0, got_d[g0]}, 32'hA5);
        chk("ov_tvalid_fall", {31'd0, m_axis_tvalid}, 32'd0);
`endif

        // Frame error with a following break, then a clean byte; prescale is
        // changed mid-frame and must not disturb that byte.
        vr0 = vr_n; fe0 = fe_n; g0 = got_n;
        send_frame(8'hC3, 1'b0, 16, 1'b0, t);
        step(100);
        chk("fe_n", fe_n - fe0, 1);
        chk("fe_edge", fe_edge, t + 155);
        chk("fe_no_valid", vr_n - vr0, 0);
        chk("fe_wait_high", {31'd0, busy}, 32'd1);
        rxd = 1'b1;
        step(20);
        chk("fe_released", {31'd0, busy}, 32'd0);
        send_frame(8'h81, 1'b1, 16, 1'b1, t);
        rxd = 1'b1;
        prescale = 16'd2;
        step(10);
        chk("b81_count", got_n - g0, 1);
        chk("b81_data", {24'd0, got_d[g0]}, 32'h81);
        chk("b81_edge", got_e[g0], t + 155);
        chk("b81_fe_once", fe_n - fe0, 1);

        // prescale=0 behaves as P=1: 8-cycle bits, tvalid at T+79.
        prescale = 16'd0;
        g0 = got_n;
        send_frame(8'h3A, 1'b1, 8, 1'b0, t);
        rxd = 1'b1;
        step(10);
        chk("p1_data", {24'd0, got_d[g0]}, 32'h3A);
        chk("p1_edge", got_e[g0], t + 79);
        prescale = 16'd2;

        // Three-cycle glitch: abandoned at the start sample.
        vr0 = vr_n; fe0 = fe_n; oe0 = oe_n;
        t = cyc + 1;
        rxd = 1'b0;
        step(3);
        rxd = 1'b1;
        step(20);
        chk("gl_no_valid", vr_n - vr0, 0);
        chk("gl_no_err", (fe_n - fe0) + (oe_n - oe0), 0);
        chk("gl_busy_rise", bz_rise, t + 2);
        chk("gl_busy_fall", bz_fall, t + 10);

        // Reset during data bit 4 of 0xF0, then 0x0F.
        vr0 = vr_n; g0 = got_n;
        rxd = 1'b0;
        step(16);
        for (int i = 0; i < 4; i++) begin
            rxd = 1'b0;
            step(16);
        end
        rxd = 1'b1;
        step(8);
        rst = 1'b1;
        #1;
        chk("mr_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        chk("mr_tdata", {24'd0, m_axis_tdata}, 32'h00);
        chk("mr_busy", {31'd0, busy}, 32'd0);
        chk("mr_errs", {30'd0, frame_error, overrun_error}, 32'd0);
        step(3);
        rst = 1'b0;
        step(10);
        send_frame(8'h0F, 1'b1, 16, 1'b0, t);
        rxd = 1'b1;
        step(10);
        chk("mr_count", got_n - g0, 1);
        chk("mr_data", {24'd0, got_d[g0]}, 32'h0F);
        chk("mr_rise_n", vr_n - vr0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
